// File: rtl/rom_stream_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// rom_stream_reader : sweeps a synchronous ROM and streams words through a
// 4-entry valid/ready FIFO.  Rev 1.0
// ============================================================================
module rom_stream_reader #(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 8,
   parameter int RD_LAT     = 1,
   parameter int START_ADDR = 0,
   parameter int END_ADDR   = 31
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic              start,
   input  logic              loop_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              busy,
   output logic              done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   localparam int FIFO_DEPTH = 4;
   localparam int INF_W      = $clog2(RD_LAT + 1);

   localparam logic [ADDR_W-1:0] C_START = ADDR_W'(START_ADDR);
   localparam logic [ADDR_W-1:0] C_END   = ADDR_W'(END_ADDR);

   logic [1:0]        state_q,    state_d;
   logic [ADDR_W-1:0] addr_q,     addr_d;
   logic              done_q,     done_d;
   logic [RD_LAT-1:0] vld_q,      vld_d;
   logic [RD_LAT-1:0] lst_q,      lst_d;
   logic [INF_W-1:0]  inflight_q, inflight_d;
   logic [2:0]        count_q,    count_d;
   logic [1:0]        wr_ptr_q,   wr_ptr_d;
   logic [1:0]        rd_ptr_q,   rd_ptr_d;
   logic [DATA_W:0]   mem_q [FIFO_DEPTH];

   logic [3:0]        w_occupancy;
   logic              w_issue;
   logic              w_at_end;
   logic              w_capture;
   logic              w_cap_last;
   logic              w_pop;
   logic [DATA_W:0]   w_head;

   // Reads in flight are counted against FIFO space so a returning word
   // always has a slot waiting for it.
   assign w_occupancy = {1'b0, count_q} + 4'(inflight_q);
   assign w_issue     = (state_q == S_RUN) && (w_occupancy < 4'd4);
   assign w_at_end    = (addr_q == C_END);
   assign w_capture   = vld_q[RD_LAT-1];
   assign w_cap_last  = lst_q[RD_LAT-1];
   assign w_pop       = m_valid && m_ready;

   generate
      if (RD_LAT == 1) begin : g_lat_single
         assign vld_d = w_issue;
         assign lst_d = w_issue && w_at_end;
      end else begin : g_lat_multi
         assign vld_d = {vld_q[RD_LAT-2:0], w_issue};
         assign lst_d = {lst_q[RD_LAT-2:0], w_issue && w_at_end};
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               addr_d  = C_START;
            end
         end
         S_RUN: begin
            if (w_issue) begin
               if (w_at_end) begin
                  if (loop_en) begin
                     addr_d = C_START;
                  end else begin
                     state_d = S_DRAIN;
                  end
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
         S_DRAIN: begin
            if ((inflight_q == '0) && (count_q == 3'd0)) begin
               state_d = S_IDLE;
               addr_d  = C_START;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            addr_d  = C_START;
         end
      endcase
   end

   always_comb begin
      inflight_d = inflight_q + INF_W'(w_issue) - INF_W'(w_capture);
      count_d    = count_q + 3'(w_capture) - 3'(w_pop);
      wr_ptr_d   = wr_ptr_q + 2'(w_capture);
      rd_ptr_d   = rd_ptr_q + 2'(w_pop);
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= C_START;
         done_q     <= 1'b0;
         vld_q      <= '0;
         lst_q      <= '0;
         inflight_q <= '0;
         count_q    <= 3'd0;
         wr_ptr_q   <= 2'd0;
         rd_ptr_q   <= 2'd0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         done_q     <= done_d;
         vld_q      <= vld_d;
         lst_q      <= lst_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Storage needs no reset: the head is masked whenever the FIFO is empty.
   always_ff @(posedge sys_clk) begin
      if (w_capture) begin
         mem_q[wr_ptr_q] <= {w_cap_last, rom_data};
      end
   end

   assign w_head   = mem_q[rd_ptr_q];
   assign m_valid  = (count_q != 3'd0);
   assign m_data   = m_valid ? w_head[DATA_W-1:0] : '0;
   assign m_last   = m_valid && w_head[DATA_W];
   assign rom_addr = addr_q;
   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_rom_stream_reader : scoreboard bench for rom_stream_reader (RD_LAT 1 and 2).
// Rev 1.0
// ============================================================================
module tb_rom_stream_reader;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       start_a, loop_en_a, m_ready_a;
   logic [4:0] rom_addr_a;
   logic [7:0] rom_data_a = 8'h00;
   logic [7:0] m_data_a;
   logic       m_valid_a, m_last_a, busy_a, done_a;

   logic       start_b, loop_en_b, m_ready_b;
   logic [4:0] rom_addr_b;
   logic [7:0] rom_data_b = 8'h00;
   logic [7:0] m_data_b;
   logic       m_valid_b, m_last_b, busy_b, done_b;
   logic [4:0] rom_b_addr_q = 5'd0;

   rom_stream_reader #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1), .START_ADDR(0), .END_ADDR(31)) dut_a (
      .sys_clk(clk), .rst(rst), .start(start_a), .loop_en(loop_en_a),
      .rom_addr(rom_addr_a), .rom_data(rom_data_a), .m_data(m_data_a),
      .m_valid(m_valid_a), .m_ready(m_ready_a), .m_last(m_last_a),
      .busy(busy_a), .done(done_a));

   rom_stream_reader #(.ADDR_W(5), .DATA_W(8), .RD_LAT(2), .START_ADDR(0), .END_ADDR(31)) dut_b (
      .sys_clk(clk), .rst(rst), .start(start_b), .loop_en(loop_en_b),
      .rom_addr(rom_addr_b), .rom_data(rom_data_b), .m_data(m_data_b),
      .m_valid(m_valid_b), .m_ready(m_ready_b), .m_last(m_last_b),
      .busy(busy_b), .done(done_b));

   // ROM contents are addr ^ 8'hA5 with one or two clocks of read latency.
   always @(posedge clk) begin
      rom_data_a   <= {3'b0, rom_addr_a} ^ 8'hA5;
      rom_b_addr_q <= rom_addr_b;
      rom_data_b   <= {3'b0, rom_b_addr_q} ^ 8'hA5;
   end

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   logic [8:0] q_a[$];
   logic [8:0] q_b[$];
   int acc_a = 0, done_cnt_a = 0, gaps_a = 0, last_acc_a = -1;
   int acc_b = 0, done_cnt_b = 0;
   logic       hold_a = 1'b0, hold_b = 1'b0;
   logic [8:0] hold_w_a, hold_w_b;

   always @(negedge clk) begin : mon_a
      logic [8:0] e;
      if (rst) begin
         hold_a = 1'b0;
      end else begin
         if (done_a) begin
            done_cnt_a++;
            chk("busy_low_at_done_a", 32'(busy_a), 32'd0);
         end
         if (hold_a)
            chk("stall_hold_a", {22'b0, m_valid_a, m_last_a, m_data_a}, {22'b0, 1'b1, hold_w_a});
         if (m_valid_a && m_ready_a) begin
            if (q_a.size() == 0) begin
               checks++; errors++;
               $display("FAIL extra_word_a: got %0h, expected none", {m_last_a, m_data_a});
            end else begin
               e = q_a.pop_front();
               chk("word_a", {23'b0, m_last_a, m_data_a}, {23'b0, e});
            end
            if (last_acc_a >= 0 && cyc != last_acc_a + 1) gaps_a++;
            last_acc_a = cyc;
            acc_a++;
         end
         hold_a   = m_valid_a && !m_ready_a;
         hold_w_a = {m_last_a, m_data_a};
      end
   end

   always @(negedge clk) begin : mon_b
      logic [8:0] e;
      if (rst) begin
         hold_b = 1'b0;
      end else begin
         if (done_b) done_cnt_b++;
         if (hold_b)
            chk("stall_hold_b", {22'b0, m_valid_b, m_last_b, m_data_b}, {22'b0, 1'b1, hold_w_b});
         if (m_valid_b && m_ready_b) begin
            if (q_b.size() == 0) begin
               checks++; errors++;
               $display("FAIL extra_word_b: got %0h, expected none", {m_last_b, m_data_b});
            end else begin
               e = q_b.pop_front();
               chk("word_b", {23'b0, m_last_b, m_data_b}, {23'b0, e});
            end
            acc_b++;
         end
         hold_b   = m_valid_b && !m_ready_b;
         hold_w_b = {m_last_b, m_data_b};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_a(input int sweeps);
      for (int s = 0; s < sweeps; s++)
         for (int i = 0; i < 32; i++)
            q_a.push_back({(i == 31), 8'(i) ^ 8'hA5});
   endtask

   task automatic pulse_start_a();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
   endtask

   // Runs until stop_acc more words are accepted (or, if 0, until done pulses).
   task automatic run_a(input bit rnd, input int stop_acc, input int budget);
      int dc0 = done_cnt_a;
      int a0  = acc_a;
      int n;
      for (n = 0; n < budget; n++) begin
         tick();
         if (stop_acc > 0 ? (acc_a - a0 >= stop_acc) : (done_cnt_a != dc0)) break;
         m_ready_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (n == budget) begin
         checks++; errors++;
         $display("FAIL timeout_a: got no event in %0d cycles, expected event", budget);
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got simulation still running, expected finish");
      $fatal(1);
   end

   initial begin : stim
      int dc, a0, n;
      rst = 1'b1;
      start_a = 1'b0; loop_en_a = 1'b0; m_ready_a = 1'b0;
      start_b = 1'b0; loop_en_b = 1'b0; m_ready_b = 1'b0;
      tick(); tick();
      @(negedge clk);
      chk("rst_m_valid", 32'(m_valid_a), 32'd0);
      chk("rst_busy",    32'(busy_a),    32'd0);
      chk("rst_done",    32'(done_a),    32'd0);
      chk("rst_addr",    32'(rom_addr_a), 32'd0);
      chk("rst_m_data",  32'(m_data_a),  32'd0);
      chk("rst_m_last",  32'(m_last_a),  32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Basic sweep, full throughput.
      push_a(1); dc = done_cnt_a; a0 = acc_a; last_acc_a = -1; gaps_a = 0;
      m_ready_a = 1'b1;
      pulse_start_a();
      run_a(1'b0, 0, 200);
      repeat (4) tick();
      chk("t2_done_once", 32'(done_cnt_a - dc), 32'd1);
      chk("t2_words",     32'(acc_a - a0),      32'd32);
      chk("t2_no_gaps",   32'(gaps_a),          32'd0);
      chk("t2_queue",     32'(q_a.size()),      32'd0);
      chk("t2_busy",      32'(busy_a),          32'd0);

      // Random backpressure.
      push_a(1); dc = done_cnt_a; a0 = acc_a;
      pulse_start_a();
      run_a(1'b1, 0, 2000);
      m_ready_a = 1'b1;
      repeat (4) tick();
      chk("t3_done_once", 32'(done_cnt_a - dc), 32'd1);
      chk("t3_words",     32'(acc_a - a0),      32'd32);
      chk("t3_queue",     32'(q_a.size()),      32'd0);

      // Looping: clear loop_en after 80 words; the third sweep still completes.
      push_a(3); dc = done_cnt_a; a0 = acc_a;
      loop_en_a = 1'b1;
      pulse_start_a();
      run_a(1'b0, 80, 500);
      chk("t4_done_none_yet", 32'(done_cnt_a - dc), 32'd0);
      loop_en_a = 1'b0;
      run_a(1'b0, 0, 500);
      repeat (4) tick();
      chk("t4_done_once", 32'(done_cnt_a - dc), 32'd1);
      chk("t4_words",     32'(acc_a - a0),      32'd96);
      chk("t4_queue",     32'(q_a.size()),      32'd0);
      chk("t4_addr_home", 32'(rom_addr_a),      32'd0);

      // Reset at word 10 discards everything.
      push_a(1); dc = done_cnt_a;
      pulse_start_a();
      run_a(1'b0, 10, 200);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      q_a.delete();
      @(negedge clk);
      chk("t5_m_valid", 32'(m_valid_a),  32'd0);
      chk("t5_busy",    32'(busy_a),     32'd0);
      chk("t5_addr",    32'(rom_addr_a), 32'd0);
      tick();
      push_a(1); a0 = acc_a;
      pulse_start_a();
      run_a(1'b0, 0, 200);
      repeat (4) tick();
      chk("t5_done_once", 32'(done_cnt_a - dc), 32'd1);
      chk("t5_words",     32'(acc_a - a0),      32'd32);
      chk("t5_queue",     32'(q_a.size()),      32'd0);

      // Second start mid-sweep is ignored.
      push_a(1); dc = done_cnt_a; a0 = acc_a;
      pulse_start_a();
      run_a(1'b0, 5, 200);
      pulse_start_a();
      run_a(1'b0, 0, 200);
      repeat (10) tick();
      chk("t6_done_once", 32'(done_cnt_a - dc), 32'd1);
      chk("t6_words",     32'(acc_a - a0),      32'd32);
      chk("t6_queue",     32'(q_a.size()),      32'd0);
      chk("t6_busy",      32'(busy_a),          32'd0);

      // RD_LAT=2 with the sink stalled: four words buffered, address frozen.
      for (int i = 0; i < 32; i++) q_b.push_back({(i == 31), 8'(i) ^ 8'hA5});
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      repeat (20) tick();
      @(negedge clk);
      chk("t7_addr_frozen", 32'(rom_addr_b), 32'd4);
      chk("t7_m_valid",     32'(m_valid_b),  32'd1);
      chk("t7_head",        32'(m_data_b),   32'hA5);
      chk("t7_head_last",   32'(m_last_b),   32'd0);
      tick();
      m_ready_b = 1'b1;
      for (n = 0; n < 200 && done_cnt_b == 0; n++) tick();
      if (done_cnt_b == 0) begin
         checks++; errors++;
         $display("FAIL timeout_b: got no done in 200 cycles, expected done");
      end
      repeat (4) tick();
      chk("t7_done_once", 32'(done_cnt_b),  32'd1);
      chk("t7_words",     32'(acc_b),       32'd32);
      chk("t7_queue",     32'(q_b.size()),  32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rom_stream_reader.md
ROM_STREAM_READER -- requirements
Module: rom_stream_reader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, meaning the ROM address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the ROM data width.
REQ-003 The block SHALL have parameter RD_LAT, default 1, legal 1..2, meaning ROM read latency in clocks from addr to data.
REQ-004 The block SHALL have parameter START_ADDR, default 0, meaning the first address of a sweep.
REQ-005 The block SHALL have parameter END_ADDR, default 31, meaning the last address of a sweep; END_ADDR >= START_ADDR.
REQ-006 The block SHALL have port sys_clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 The block SHALL have port start, input, 1, sweep request, sampled only in IDLE.
REQ-009 The block SHALL have port loop_en, input, 1, when 1 the sweep wraps END_ADDR->START_ADDR indefinitely.
REQ-010 The block SHALL have port rom_addr, output, ADDR_W, address to the synchronous ROM.
REQ-011 The block SHALL have port rom_data, input, DATA_W, ROM output, valid RD_LAT clocks after rom_addr is issued.
REQ-012 The block SHALL have port m_data, output, DATA_W, stream data.
REQ-013 The block SHALL have port m_valid, output, 1, stream data valid.
REQ-014 The block SHALL have port m_ready, input, 1, downstream accept.
REQ-015 The block SHALL have port m_last, output, 1, marks the word read from END_ADDR.
REQ-016 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-017 The block SHALL have port done, output, 1, one-cycle pulse on sweep completion.

Function
REQ-018 States SHALL be IDLE, RUN, DRAIN; IDLE->RUN on start=1, rom_addr loaded with START_ADDR.
REQ-019 In RUN a read SHALL be issued in a cycle only if (fifo_count + inflight) < 4; an issue advances rom_addr by 1 next cycle.
REQ-020 A 4-entry output FIFO SHALL hold returned words with their last flag; inflight counts issued reads not yet captured (0..RD_LAT).
REQ-021 An issued read SHALL be captured into the FIFO exactly RD_LAT cycles later via a per-stage valid/last shift register.
REQ-022 On issuing END_ADDR: loop_en=1 -> rom_addr wraps to START_ADDR, stay RUN; loop_en=0 -> go DRAIN, no further issues.
REQ-023 loop_en changes mid-sweep SHALL take effect at the next END_ADDR issue only.
REQ-024 DRAIN->IDLE SHALL occur when inflight=0, FIFO empty; done=1 for that single cycle.
REQ-025 m_valid SHALL equal FIFO non-empty; m_data/m_last come from FIFO head; pop on m_valid&m_ready.
REQ-026 m_data/m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-027 Simultaneous capture and pop SHALL leave fifo_count unchanged; FIFO SHALL never overflow nor drop a word.
REQ-028 start SHALL be ignored when not in IDLE.
REQ-029 Words SHALL appear in address order with no gaps or duplicates; each sweep yields END_ADDR-START_ADDR+1 words.
REQ-030 With m_ready held 1, throughput SHALL be one word per clock after RD_LAT+1 cycles of latency from start.

Reset
REQ-031 While rst=1: state IDLE, rom_addr=START_ADDR, fifo_count=0, inflight=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0.
REQ-032 rst asserted mid-sweep SHALL discard all in-flight and buffered words; no m_valid in the cycle after rst deasserts.

Verification
REQ-033 ROM model data=addr^8'hA5, RD_LAT=1, start pulse, m_ready=1, loop_en=0 -> 32 words A5,A4,... in order, m_last on word 32 (8'hBA), done once, busy falls with done.
REQ-034 Same with m_ready toggling 1-0-0-1 randomly -> identical 32-word sequence, no loss/duplicate, data stable while stalled, fifo_count never >4.
REQ-035 loop_en=1, m_ready=1, 80 accepted words -> address sequence 0..31,0..31,0..15, m_last on words 32 and 64; clear loop_en -> stops after next addr 31, done pulses.
REQ-036 RD_LAT=2, m_ready=0 for 20 cycles after start -> exactly 4 words buffered, rom_addr frozen at 4; release -> remaining sequence correct.
REQ-037 rst=1 for one cycle at word 10 of a sweep -> next cycle m_valid=0, busy=0, rom_addr=0; new start yields full sweep from addr 0.
REQ-038 start pulsed again at word 5 -> ignored; exactly one sweep of 32 words and one done pulse.
